// File: rtl/trunc_mask_ctrl_pkg.sv
// trunc_pkg: shared types and helpers for trunc_mask_ctrl.
// Holds the channel state enum, mode encoding and the level-to-mask rule.
package trunc_pkg;

  localparam int MAX_DATA_W = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } ch_state_e;

  typedef logic ch_mode_t;

  localparam ch_mode_t MODE_STATIC = 1'b0;
  localparam ch_mode_t MODE_RAMP   = 1'b1;

  // nbits(k) = 2k + (k mod 2), capped so the MSB is never cleared.
  function automatic logic [MAX_DATA_W-1:0] level_to_mask(
    input int level,
    input int data_w
  );
    int                    nbits;
    logic [MAX_DATA_W-1:0] m;
    nbits = 2 * level + (level % 2);
    if (nbits > data_w - 1) nbits = data_w - 1;
    m = '0;
    for (int i = 0; i < MAX_DATA_W; i++) begin
      m[i] = (i < nbits);
    end
    return m;
  endfunction

endpackage

// File: rtl/trunc_mask_ctrl_if.sv
// trunc_cfg_if: config request channel for trunc_mask_ctrl.
// Ports: cfg_valid/cfg_ready handshake, cfg_ch, cfg_level, cfg_ramp.
interface trunc_cfg_if #(
  parameter int CH_W    = 2,
  parameter int LEVEL_W = 4
);

  logic               cfg_valid;
  logic               cfg_ready;
  logic [CH_W-1:0]    cfg_ch;
  logic [LEVEL_W-1:0] cfg_level;
  logic               cfg_ramp;

  modport master (
    output cfg_valid,
    output cfg_ch,
    output cfg_level,
    output cfg_ramp,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_ch,
    input  cfg_level,
    input  cfg_ramp,
    output cfg_ready
  );

endinterface

// File: rtl/trunc_mask_ctrl_ch_fsm.sv
// trunc_ch_fsm: one channel of the truncation-mask controller.
// In: wr_en/wr_level/wr_ramp (accepted request), idle_i (lane idle).
// Out: busy_o, cur_o (applied level), mask_o (registered LSB mask).
module trunc_ch_fsm
  import trunc_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int LEVEL_W  = 4,
  parameter int STEP_CYC = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [LEVEL_W-1:0] wr_level,
  input  logic               wr_ramp,
  input  logic               idle_i,
  output logic               busy_o,
  output logic [LEVEL_W-1:0] cur_o,
  output logic [DATA_W-1:0]  mask_o
);

  localparam int TMR_W =
    (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD =
    TMR_W'(STEP_CYC - 1);

  ch_state_e          state_q, state_d;
  ch_mode_t           mode_q, mode_d;
  logic [LEVEL_W-1:0] tgt_q, tgt_d;
  logic [LEVEL_W-1:0] cur_q, cur_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [DATA_W-1:0]  mask_q, mask_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= MODE_STATIC;
      tgt_q   <= '0;
      cur_q   <= '0;
      timer_q <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      tgt_q   <= tgt_d;
      cur_q   <= cur_d;
      timer_q <= timer_d;
      mask_q  <= mask_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    tgt_d   = tgt_q;
    cur_d   = cur_q;
    timer_d = timer_q;
    mask_d  = mask_q;
    unique case (state_q)
      IDLE: begin
        if (wr_en && (wr_level != cur_q)) begin
          tgt_d   = wr_level;
          mode_d  = wr_ramp;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // Mask only moves while the lane is idle.
        if (idle_i) begin
          if (mode_q == MODE_RAMP) begin
            cur_d = (tgt_q > cur_q)
              ? cur_q + LEVEL_W'(1)
              : cur_q - LEVEL_W'(1);
          end else begin
            cur_d = tgt_q;
          end
          mask_d = DATA_W'(
            level_to_mask(int'(cur_d), DATA_W));
          if (cur_d == tgt_q) begin
            state_d = IDLE;
          end else begin
            state_d = HOLD;
            timer_d = TMR_LOAD;
          end
        end
      end
      HOLD: begin
        if (timer_q == '0) begin
          state_d = WAIT;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o = (state_q != IDLE);
  assign cur_o  = cur_q;
  assign mask_o = mask_q;

endmodule

// File: rtl/trunc_mask_ctrl.sv
// trunc_mask_ctrl: N_CH-channel truncation-mask controller.
// Ports: clk, rst_n, cfg (slave request port), ch_idle,
//        trunc_mask, cur_level, busy (per-channel, packed).
module trunc_mask_ctrl
  import trunc_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int LEVEL_W  = 4,
  parameter int N_CH     = 4,
  parameter int STEP_CYC = 16,
  parameter int CH_W     =
    (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  trunc_cfg_if.slave                cfg,
  input  logic [N_CH-1:0]           ch_idle,
  output logic [N_CH*DATA_W-1:0]    trunc_mask,
  output logic [N_CH*LEVEL_W-1:0]   cur_level,
  output logic [N_CH-1:0]           busy
);

  logic [N_CH-1:0] busy_w;
  logic [N_CH-1:0] wr_en;
  logic            cfg_ready_c;

  // Out-of-range channels match no entry: ready stays 1
  // and no strobe fires, so the request is dropped.
  always_comb begin
    cfg_ready_c = 1'b1;
    for (int c = 0; c < N_CH; c++) begin
      if (cfg.cfg_ch == CH_W'(c)) begin
        cfg_ready_c = !busy_w[c];
      end
    end
    wr_en = '0;
    for (int c = 0; c < N_CH; c++) begin
      wr_en[c] = cfg.cfg_valid && cfg_ready_c
        && (cfg.cfg_ch == CH_W'(c));
    end
  end

  assign cfg.cfg_ready = cfg_ready_c;
  assign busy          = busy_w;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    trunc_ch_fsm #(
      .DATA_W   (DATA_W),
      .LEVEL_W  (LEVEL_W),
      .STEP_CYC (STEP_CYC)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (wr_en[c]),
      .wr_level (cfg.cfg_level),
      .wr_ramp  (cfg.cfg_ramp),
      .idle_i   (ch_idle[c]),
      .busy_o   (busy_w[c]),
      .cur_o    (cur_level[c*LEVEL_W +: LEVEL_W]),
      .mask_o   (trunc_mask[c*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_trunc_mask_ctrl.sv
// tb_trunc_mask_ctrl: randomized + directed bench for trunc_mask_ctrl.
// Reference model tracks levels and earliest-update cycles per channel.
module tb_trunc_mask_ctrl;

  localparam int DATA_W   = 32;
  localparam int LEVEL_W  = 4;
  localparam int N_CH     = 4;
  localparam int STEP_CYC = 4;
  localparam int CH_W     = 2;

  logic clk;
  logic rst_n;
  logic [N_CH-1:0]         ch_idle;
  logic [N_CH*DATA_W-1:0]  trunc_mask;
  logic [N_CH*LEVEL_W-1:0] cur_level;
  logic [N_CH-1:0]         busy;

  trunc_cfg_if #(.CH_W(CH_W), .LEVEL_W(LEVEL_W)) cfg ();

  trunc_mask_ctrl #(
    .DATA_W   (DATA_W),
    .LEVEL_W  (LEVEL_W),
    .N_CH     (N_CH),
    .STEP_CYC (STEP_CYC)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg        (cfg),
    .ch_idle    (ch_idle),
    .trunc_mask (trunc_mask),
    .cur_level  (cur_level),
    .busy       (busy)
  );

  // Three-channel instance so cfg_ch == N_CH is expressible.
  logic [2:0]          ch_idle3;
  logic [3*DATA_W-1:0] mask3;
  logic [3*LEVEL_W-1:0] cur3;
  logic [2:0]          busy3;

  trunc_cfg_if #(.CH_W(2), .LEVEL_W(LEVEL_W)) cfg3 ();

  trunc_mask_ctrl #(
    .DATA_W   (DATA_W),
    .LEVEL_W  (LEVEL_W),
    .N_CH     (3),
    .STEP_CYC (STEP_CYC)
  ) u_dut3 (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg        (cfg3),
    .ch_idle    (ch_idle3),
    .trunc_mask (mask3),
    .cur_level  (cur3),
    .busy       (busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  int m_cur  [N_CH];
  int m_tgt  [N_CH];
  bit m_ramp [N_CH];
  bit m_pend [N_CH];
  int m_earl [N_CH];
  int cyc = 0;

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] ref_mask(input int k);
    int nb;
    nb = 2 * k + (k % 2);
    if (nb > DATA_W - 1) nb = DATA_W - 1;
    return DATA_W'((64'd1 << nb) - 64'd1);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < N_CH; c++) begin
      m_cur[c]  = 0;
      m_tgt[c]  = 0;
      m_ramp[c] = 1'b0;
      m_pend[c] = 1'b0;
      m_earl[c] = 0;
    end
  endtask

  task automatic drive(
    input logic v, input int ch,
    input int lvl, input logic r
  );
    cfg.cfg_valid = v;
    cfg.cfg_ch    = CH_W'(ch);
    cfg.cfg_level = LEVEL_W'(lvl);
    cfg.cfg_ramp  = r;
  endtask

  task automatic compare_all();
    for (int c = 0; c < N_CH; c++) begin
      check($sformatf("mask%0d", c),
        trunc_mask[c*DATA_W +: DATA_W], ref_mask(m_cur[c]));
      check($sformatf("cur%0d", c),
        cur_level[c*LEVEL_W +: LEVEL_W], m_cur[c]);
      check($sformatf("busy%0d", c), busy[c], m_pend[c]);
    end
  endtask

  // One clock: check ready, let the edge happen, advance model, compare.
  task automatic tick();
    logic            rdy;
    logic            acc;
    int              ch;
    int              lvl;
    bit              rmp;
    logic [N_CH-1:0] idl;
    #1;
    ch  = int'(cfg.cfg_ch);
    rdy = (ch >= N_CH) ? 1'b1 : !m_pend[ch];
    check("cfg_ready", cfg.cfg_ready, rdy);
    acc = cfg.cfg_valid && rdy && (ch < N_CH);
    lvl = int'(cfg.cfg_level);
    rmp = cfg.cfg_ramp;
    idl = ch_idle;
    @(posedge clk);
    cyc++;
    for (int c = 0; c < N_CH; c++) begin
      if (m_pend[c] && cyc >= m_earl[c] && idl[c]) begin
        if (m_ramp[c])
          m_cur[c] += (m_tgt[c] > m_cur[c]) ? 1 : -1;
        else
          m_cur[c] = m_tgt[c];
        if (m_cur[c] == m_tgt[c]) m_pend[c] = 1'b0;
        else m_earl[c] = cyc + STEP_CYC + 1;
      end
    end
    if (acc && lvl != m_cur[ch]) begin
      m_tgt[ch]  = lvl;
      m_ramp[ch] = rmp;
      m_pend[ch] = 1'b1;
      m_earl[ch] = cyc + 1;
    end
    #1;
    compare_all();
  endtask

  // Reset asserted between edges; outputs must clear with no clock edge.
  task automatic mid_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    check({tag, "_mask"}, trunc_mask, '0);
    check({tag, "_cur"}, cur_level, '0);
    check({tag, "_busy"}, busy, '0);
    check({tag, "_rdy"}, cfg.cfg_ready, 1'b1);
    model_reset();
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    rst_n    = 1'b1;
    ch_idle  = '1;
    ch_idle3 = '1;
    drive(1'b0, 0, 0, 1'b0);
    cfg3.cfg_valid = 1'b0;
    cfg3.cfg_ch    = '0;
    cfg3.cfg_level = '0;
    cfg3.cfg_ramp  = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_mask", trunc_mask, '0);
    check("rst_busy", busy, '0);
    check("rst_rdy", cfg.cfg_ready, 1'b1);
    #19 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Static jump on ch0.
    drive(1'b1, 0, 5, 1'b0);
    tick();
    drive(1'b0, 0, 0, 1'b0);
    check("st_busy", busy[0], 1'b1);
    tick();
    check("st_mask", trunc_mask[31:0], 32'h0000_07FF);
    check("st_cur", cur_level[3:0], 4'd5);

    // Ramp up on ch1.
    drive(1'b1, 1, 3, 1'b1);
    tick();
    drive(1'b0, 1, 0, 1'b0);
    tick();
    check("ru_m1", trunc_mask[63:32], 32'h7);
    repeat (15) tick();
    check("ru_m3", trunc_mask[63:32], 32'h7F);
    check("ru_busy", busy[1], 1'b0);

    // Stall on ch2, other channel still writable.
    ch_idle = 4'b1011;
    drive(1'b1, 2, 4, 1'b0);
    tick();
    drive(1'b1, 2, 9, 1'b0);
    repeat (10) tick();
    check("stall_mask", trunc_mask[95:64], 32'h0);
    check("stall_busy", busy[2], 1'b1);
    drive(1'b1, 3, 6, 1'b0);
    tick();
    check("stall_ch3", busy[3], 1'b1);
    drive(1'b0, 0, 0, 1'b0);
    ch_idle = 4'b1111;
    tick();
    check("stall_rel", trunc_mask[95:64], 32'hFF);

    // Ramp down 15 -> 12 on ch0, then same-level no-op.
    drive(1'b1, 0, 15, 1'b0);
    tick();
    drive(1'b0, 0, 0, 1'b0);
    tick();
    check("rd_15", trunc_mask[31:0], 32'h7FFF_FFFF);
    drive(1'b1, 0, 12, 1'b1);
    tick();
    drive(1'b0, 0, 0, 1'b0);
    repeat (16) tick();
    check("rd_12", trunc_mask[31:0], 32'h00FF_FFFF);
    drive(1'b1, 0, 12, 1'b0);
    tick();
    check("same_lvl", busy[0], 1'b0);
    drive(1'b0, 0, 0, 1'b0);

    // Out-of-range channel on the three-channel instance.
    cfg3.cfg_valid = 1'b1;
    cfg3.cfg_ch    = 2'd3;
    cfg3.cfg_level = 4'd7;
    #1;
    check("oor_rdy", cfg3.cfg_ready, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("oor_busy", busy3, 3'b000);
    check("oor_cur", cur3, '0);
    cfg3.cfg_ch = 2'd2;
    @(posedge clk);
    #1;
    cfg3.cfg_valid = 1'b0;
    check("oor_ch2", busy3, 3'b100);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 2) == 0),
        $urandom_range(0, N_CH - 1),
        $urandom_range(0, 15), $urandom_range(0, 1));
      for (int c = 0; c < N_CH; c++)
        ch_idle[c] = ($urandom_range(0, 3) != 0);
      tick();
    end
    drive(1'b0, 0, 0, 1'b0);
    ch_idle = '1;

    // Reset in the middle of a ramp.
    tick();
    mid_reset("rst0");
    drive(1'b1, 1, 10, 1'b1);
    tick();
    drive(1'b0, 0, 0, 1'b0);
    repeat (3) tick();
    check("mr_hold", busy[1], 1'b1);
    mid_reset("rst1");
    drive(1'b1, 1, 2, 1'b0);
    tick();
    check("mr_acc", busy[1], 1'b1);
    drive(1'b0, 0, 0, 1'b0);
    tick();
    check("mr_mask", trunc_mask[63:32], 32'hF);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/trunc_mask_ctrl.md
# trunc_mask_ctrl

- Multi-channel, parametrised truncation-mask controller for the approximate-arithmetic datapath.
- Each channel holds a registered truncation level and drives an LSB-zeroing mask to one datapath lane.
- Level changes are requested over a valid/ready config port and applied either as a single jump or as a timed ramp of one level per step.
- A mask only changes when the lane reports idle, so an operation in flight never sees a mask change.

## Interface
Parameters:
- DATA_W, 32, lane width; width of each mask.
- LEVEL_W, 4, truncation level width; levels 0..2^LEVEL_W-1.
- N_CH, 4, number of independent channels; minimum 1.
- STEP_CYC, 16, hold cycles between ramp steps; minimum 1.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  config accept; combinational, equals !busy[cfg_ch], or 1 when cfg_ch >= N_CH.
- cfg_ch  in  max(1,$clog2(N_CH))  target channel.
- cfg_level  in  LEVEL_W  target level.
- cfg_ramp  in  1  0 = static jump, 1 = ramp one level per step.
- ch_idle  in  N_CH  per-lane "no operation in flight".
- trunc_mask  out  N_CH*DATA_W  registered masks; channel c occupies bits [c*DATA_W +: DATA_W].
- cur_level  out  N_CH*LEVEL_W  registered applied level per channel.
- busy  out  N_CH  high when the channel state is not IDLE.

## Operation
- Level-to-mask rule: nbits(k) = 2k + (k mod 2), saturated at DATA_W-1. The mask has the low nbits bits set.
  - DATA_W=32 gives 0, 0x7, 0xF, 0x7F, 0xFF … 0x7FFFFFFF for k = 0..15.
  - The MSB is never masked.
- Accept a request when cfg_valid && cfg_ready.
  - If cfg_ch >= N_CH, the request is accepted and discarded.
  - If cfg_level equals that channel's cur_level, the request is accepted with no state change.
  - Otherwise latch tgt and mode, and go to WAIT.
- Per-channel FSM:
  - IDLE: cur == tgt. busy=0.
  - WAIT: on an edge where ch_idle[c]=1:
    - static mode: cur <= tgt.
    - ramp mode: cur <= cur±1 toward tgt.
    - The mask register is updated on the same edge from the new cur.
    - Then go to IDLE if new cur == tgt, else to HOLD with timer = STEP_CYC-1.
  - HOLD: timer counts down; at 0 go to WAIT.
- Channels are fully independent. Simultaneous updates on several channels are legal on the same edge.
- A busy channel cannot be retargeted because cfg_ready is low for it. Other channels still accept requests.

## Timing
- Reset (async assert, sync-released edge use): trunc_mask=0, cur_level=0, busy=0, all states IDLE, tgt=0, timers=0.
- cfg_ready resets to 1 (combinational from busy).
- Static latency:
  - Request accepted at edge E0; busy=1 after E0.
  - With ch_idle=1, mask/cur_level update at E1 and busy=0 after E1.
- Ramp spacing with ch_idle held high: consecutive level steps are STEP_CYC+1 cycles apart.
- ch_idle low in WAIT stalls indefinitely: no mask change, busy stays 1.
- ch_idle is only sampled in WAIT.
- Reset mid-ramp returns the channel to level 0 and IDLE immediately; the pending target is lost.

## Structure
- Package trunc_pkg holds:
  - state enum (IDLE, WAIT, HOLD);
  - mode constant (MODE_STATIC, MODE_RAMP);
  - function level_to_mask(level, DATA_W) implementing the nbits rule.
- Sub-module trunc_ch_fsm holds one channel's FSM, timer, tgt/cur/mask registers and busy.
  - The top generates N_CH instances, decodes cfg_ch into per-channel write strobes, and muxes cfg_ready.

## Test plan
- Reset: rst_n low mid-cycle → all trunc_mask 0, cur_level 0, busy 0, cfg_ready 1 without waiting for a clock edge.
- Static jump: ch0 level 5, cfg_ramp=0, ch_idle=1 → busy[0] high for one cycle, then trunc_mask ch0 = 0x000007FF, cur_level 5.
- Ramp up: ch1 0→3, STEP_CYC=4, ch_idle=1 → masks 0x7, 0xF, 0x7F at cycle spacing 5, then busy[1]=0.
- Stall: ch2 level 4 static with ch_idle[2]=0 for 10 cycles.
  - Mask stays 0, busy[2]=1, cfg_ready=0 for cfg_ch=2.
  - A write to ch3 is accepted.
  - Raise ch_idle[2] → 0xFF on the next edge.
- Ramp down plus edge cases: ch0 15→12 ramp → 0x7FFFFFFF, 0x0FFFFFFF, 0x07FFFFFF, 0x00FFFFFF.
  - cfg_ch=N_CH is accepted and ignored.
  - Writing the same level is a no-op with busy staying 0.
- Reset mid-ramp: assert rst_n during HOLD of a 0→10 ramp → mask 0 and IDLE; after release a new request is accepted on the first cycle.
